// File: rtl/puf_pkg.sv
// Shared types and default widths for the RO-PUF challenge sequencer.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPT,
        STORE,
        FIN
    } puf_state_e;

    localparam int DEF_CHALL_W = 8;
    localparam int DEF_WORD_W  = 32;
    localparam int DEF_ADDR_W  = 5;

endpackage

// File: rtl/puf_resp_packer.sv
// Packs comparator bits LSB-first into a response word and tracks the RAM word index.
module puf_resp_packer
    import puf_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              cap,
    input  logic              cap_bit,
    input  logic              adv,
    input  logic              next_word,
    output logic              full,
    output logic [WORD_W-1:0] word,
    output logic [ADDR_W-1:0] word_idx
);

    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

    logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;

    always_comb begin
        bit_idx_d  = bit_idx_q;
        word_d     = word_q;
        word_idx_d = word_idx_q;
        if (clr) begin
            bit_idx_d  = '0;
            word_d     = '0;
            word_idx_d = '0;
        end
        if (cap) begin
            word_d[bit_idx_q] = cap_bit;
        end
        if (adv) begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
        end
        if (next_word) begin
            bit_idx_d  = '0;
            word_d     = '0;
            word_idx_d = word_idx_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_idx_q  <= '0;
            word_q     <= '0;
            word_idx_q <= '0;
        end else begin
            bit_idx_q  <= bit_idx_d;
            word_q     <= word_d;
            word_idx_q <= word_idx_d;
        end
    end

    assign full     = (bit_idx_q == LAST_BIT);
    assign word     = word_q;
    assign word_idx = word_idx_q;

endmodule

// File: rtl/puf_chall_seq.sv
// RO-PUF challenge sequencer: issues one measurement per challenge pair and stores packed responses.
// state | meaning
// IDLE  | waiting for start; done/err hold the last run's result
// ISSUE | pulse meas_start with the current challenge pair
// WAIT  | wait for meas_done or the timeout terminal count
// CAPT  | decide between next challenge and storing the word
// STORE | write the packed word to the response RAM
// FIN   | run complete, raise done
module puf_chall_seq
    import puf_pkg::*;
#(
    parameter int CHALL_W      = DEF_CHALL_W,
    parameter int NUM_CHALL    = 256,
    parameter int CHALL_OFFSET = 1,
    parameter int WORD_W       = DEF_WORD_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int TIMEOUT      = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [CHALL_W-1:0] chall0,
    output logic [CHALL_W-1:0] chall1,
    output logic               meas_start,
    input  logic               meas_done,
    input  logic               resp_bit,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [WORD_W-1:0]  ram_data,
    output logic               ram_wren,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(TIMEOUT - 1);
    localparam logic [CHALL_W-1:0] LAST_IDX = CHALL_W'(NUM_CHALL - 1);
    localparam logic [CHALL_W-1:0] OFFS     = CHALL_W'(CHALL_OFFSET);
    localparam logic [CHALL_W-1:0] ONE      = CHALL_W'(1);

    puf_state_e         state_q, state_d;
    logic [CHALL_W-1:0] idx_q, idx_d, chall1_q, chall1_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               done_q, done_d, err_q, err_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [WORD_W-1:0]  ram_data_q, ram_data_d;

    logic               pk_clr, pk_cap, pk_bit, pk_adv, pk_next_word, pk_full;
    logic [WORD_W-1:0]  pk_word;
    logic [ADDR_W-1:0]  pk_word_idx;
    logic               last;

    assign last = (idx_q == LAST_IDX);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        chall1_d     = chall1_q;
        tmr_d        = tmr_q;
        done_d       = done_q;
        err_d        = err_q;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        pk_clr       = 1'b0;
        pk_cap       = 1'b0;
        pk_bit       = 1'b0;
        pk_adv       = 1'b0;
        pk_next_word = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ISSUE;
                    idx_d    = '0;
                    chall1_d = OFFS;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    pk_clr   = 1'b1;
                end
            end
            ISSUE: begin
                tmr_d   = TMR_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                // a meas_done arriving on the terminal-count cycle still counts as valid
                if (meas_done) begin
                    pk_cap  = 1'b1;
                    pk_bit  = resp_bit;
                    state_d = CAPT;
                end else if (tmr_q == '0) begin
                    pk_cap  = 1'b1;
                    err_d   = 1'b1;
                    state_d = CAPT;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            CAPT: begin
                if (last || pk_full) begin
                    ram_addr_d = pk_word_idx;
                    ram_data_d = pk_word;
                    state_d    = STORE;
                end else begin
                    pk_adv   = 1'b1;
                    idx_d    = idx_q + ONE;
                    chall1_d = idx_q + ONE + OFFS;
                    state_d  = ISSUE;
                end
            end
            STORE: begin
                if (last) begin
                    done_d  = 1'b1;
                    state_d = FIN;
                end else begin
                    pk_next_word = 1'b1;
                    idx_d        = idx_q + ONE;
                    chall1_d     = idx_q + ONE + OFFS;
                    state_d      = ISSUE;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            chall1_q   <= '0;
            tmr_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            chall1_q   <= chall1_d;
            tmr_q      <= tmr_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
        end
    end

    puf_resp_packer #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pk_clr),
        .cap       (pk_cap),
        .cap_bit   (pk_bit),
        .adv       (pk_adv),
        .next_word (pk_next_word),
        .full      (pk_full),
        .word      (pk_word),
        .word_idx  (pk_word_idx)
    );

    assign chall0     = idx_q;
    assign chall1     = chall1_q;
    assign meas_start = (state_q == ISSUE);
    assign ram_wren   = (state_q == STORE);
    assign ram_addr   = ram_addr_q;
    assign ram_data   = ram_data_q;
    assign busy       = (state_q == ISSUE) || (state_q == WAIT) ||
                        (state_q == CAPT)  || (state_q == STORE);
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: doc/puf_chall_seq.md
Name: puf_chall_seq

Overview:
- Upstream sequencer and downstream collector for the RO-PUF measurement path.
- Steps through NUM_CHALL challenge pairs and drives the two 256:1 RO mux selects.
- For each pair, hands off one measurement to the counter/comparator controller and waits for its done pulse.
- Packs the returned comparator bits into WORD_W-bit words and writes each word to the response RAM at an incrementing address.

Parameters:
- CHALL_W, 8, challenge (mux select) width.
- NUM_CHALL, 256, challenge pairs per run; range 1..2^CHALL_W.
- CHALL_OFFSET, 1, chall1 = chall0 + CHALL_OFFSET mod 2^CHALL_W.
- WORD_W, 32, response bits packed per RAM word.
- ADDR_W, 5, RAM address width; must satisfy ceil(NUM_CHALL/WORD_W) <= 2^ADDR_W.
- TIMEOUT, 4096, cycles allowed in WAIT before a measurement is declared lost.

Ports:
- clk, in, 1, system clock; all state changes on its rising edge.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, single-cycle run request.
- chall0, out, CHALL_W, select for RO bank 0 mux.
- chall1, out, CHALL_W, select for RO bank 1 mux.
- meas_start, out, 1, one-cycle pulse requesting one measurement.
- meas_done, in, 1, one-cycle pulse: measurement complete, resp_bit valid.
- resp_bit, in, 1, comparator result; sampled only with meas_done in WAIT.
- ram_addr, out, ADDR_W, RAM word address.
- ram_data, out, WORD_W, packed response word.
- ram_wren, out, 1, RAM write strobe.
- busy, out, 1, run in progress.
- done, out, 1, run finished; level signal.
- err, out, 1, sticky: at least one timeout occurred this run.

Behaviour:
- Reset (rst=0, asynchronous): every output is 0; state IDLE; all counters and the shift word cleared. Reset mid-run aborts immediately; no partial word is written.
- State IDLE: busy=0.
  - start=1 -> ISSUE.
  - On that transition: chall index=0, bit_idx=0, word_idx=0, shift word=0, done=0, err=0.
- State ISSUE, one cycle:
  - meas_start=1.
  - chall0=index and chall1=index+CHALL_OFFSET (mod 2^CHALL_W), held stable from ISSUE through the end of WAIT.
  - -> WAIT; timeout counter cleared.
- State WAIT:
  - meas_done=1: word[bit_idx]=resp_bit, LSB first, then -> CAPT.
  - Timeout counter reaches TIMEOUT-1 with no meas_done: word[bit_idx]=0, err=1, then -> CAPT.
  - meas_done and timeout in the same cycle: meas_done wins and err is not set.
- State CAPT, one cycle:
  - If index==NUM_CHALL-1 or bit_idx==WORD_W-1: -> STORE.
  - Otherwise: bit_idx++, index++, -> ISSUE.
- State STORE, one cycle:
  - ram_wren=1, ram_addr=word_idx, ram_data=shift word.
  - Final partial word: unfilled upper bits are 0.
  - Then, if last challenge: -> FIN.
  - Otherwise: word_idx++, bit_idx=0, shift word=0, index++, -> ISSUE.
- State FIN: busy=0, done=1, -> IDLE. done stays high until the next accepted start.
- busy=1 in ISSUE, WAIT, CAPT and STORE.
- start is ignored when busy=1.
- meas_done is ignored outside WAIT.
- ram_wren is 0 outside STORE. ram_addr and ram_data hold their last values.
- Per-challenge latency: 3 cycles (ISSUE, CAPT, plus the meas_done cycle) plus the measurement time, plus 1 cycle per stored word.

Decomposition:
- Shared package puf_pkg holds:
  - the state enum: IDLE, ISSUE, WAIT, CAPT, STORE, FIN;
  - default constants CHALL_W, WORD_W, ADDR_W.
- One natural sub-module, puf_resp_packer: bit_idx counter, shift word, word_idx, and the clear/shift/full controls.

Test Plan:
- NUM_CHALL=8, WORD_W=4, CHALL_OFFSET=1, model answers meas_done 5 cycles after each meas_start with resp_bit=index[0] -> challenge pairs (0,1)..(7,8); RAM writes addr0=4'hA, addr1=4'hA; done=1; err=0.
- NUM_CHALL=6, WORD_W=4, resp_bit=1 for every challenge -> addr0=4'hF, addr1=4'h3 (zero-padded); exactly 2 writes.
- TIMEOUT=16, model never answers index 2 -> err=1, bit 2 of word 0 is 0, run completes; err stays 1 until the next start.
- start pulsed while busy, and meas_done pulsed in IDLE -> no state change, no extra meas_start.
- rst driven low while in WAIT of index 5 -> all outputs 0 the same cycle, no ram_wren; a following start restarts at chall0=0.
- CHALL_W=8, index=255, CHALL_OFFSET=1 -> chall1=0 (wrap-around).
